// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatcher: opcodes, flag indices,
// instruction field helpers and the dispatcher FSM state type.
// Optional feature macro: ALU_DISPATCH_LDI_EN (op 0xF becomes LDI).
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_PASS = 4'h8;
  localparam logic [3:0] OP_ADC  = 4'h9;
  localparam logic [3:0] OP_SBC  = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hF;

  // Bit positions inside the {neg, carry, zero} flag vector
  localparam int unsigned ZF = 0;
  localparam int unsigned CF = 1;
  localparam int unsigned NF = 2;

  localparam int unsigned INSTR_W = 16;

`ifdef ALU_DISPATCH_LDI_EN
  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWb, StLdiWb} state_e;
`else
  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWb} state_e;
`endif

  function automatic logic [3:0] op_f(input logic [INSTR_W-1:0] w);
    return w[15:12];
  endfunction

  function automatic logic [2:0] rd_f(input logic [INSTR_W-1:0] w);
    return w[11:9];
  endfunction

  function automatic logic [2:0] rs1_f(input logic [INSTR_W-1:0] w);
    return w[8:6];
  endfunction

  function automatic logic [2:0] rs2_f(input logic [INSTR_W-1:0] w);
    return w[5:3];
  endfunction

  function automatic logic [7:0] imm_f(input logic [INSTR_W-1:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two combinational operand read ports,
// one combinational debug read port, one synchronous write port.
// Addresses beyond NREGS read as zero and ignore writes.
module alu_regfile #(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  input  logic [2:0]        raddr_b,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] rf_q [NREGS];

  function automatic logic in_range(input logic [2:0] a);
    return {29'd0, a} < NREGS;
  endfunction

  // Storage: cleared asynchronously, single write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we && in_range(waddr)) begin
      rf_q[waddr] <= wdata;
    end
  end

  // Read ports
  always_comb begin
    rdata_a   = in_range(raddr_a)   ? rf_q[raddr_a]   : '0;
    rdata_b   = in_range(raddr_b)   ? rf_q[raddr_b]   : '0;
    dbg_rdata = in_range(dbg_raddr) ? rf_q[dbg_raddr] : '0;
  end

endmodule

// File: rtl/alu_dispatch.sv
// Serial issue stage for the 8-bit ALU: accepts one instruction at a time,
// issues operands for one cycle, waits ALU_LAT cycles, then writes back.
// Optional feature macro: ALU_DISPATCH_LDI_EN (op 0xF loads an immediate).
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned NREGS   = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_flags,
  output logic [2:0]        flags_q,
  output logic              retire,
  output logic              illegal,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_sel_q;
  logic              illegal_q, illegal_d;
  logic              accept, is_alu_op, is_ldi;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata, rf_a, rf_b;

  assign accept    = instr_valid && instr_ready;
  assign is_alu_op = op_f(instr) <= OP_SBC;
`ifdef ALU_DISPATCH_LDI_EN
  assign is_ldi    = op_f(instr) == OP_LDI;
`else
  assign is_ldi    = 1'b0;
  // Immediate bits are only consumed by LDI
  logic unused_imm;
  assign unused_imm = ^instr_q[2:0];
`endif

  alu_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rd_f(instr_q)),
    .wdata     (rf_wdata),
    .raddr_a   (rs1_f(instr_q)),
    .raddr_b   (rs2_f(instr_q)),
    .dbg_raddr (dbg_raddr),
    .rdata_a   (rf_a),
    .rdata_b   (rf_b),
    .dbg_rdata (dbg_rdata)
  );

  // Next-state, wait counter and register-file write control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = alu_out;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_alu_op)   state_d = StIssue;
`ifdef ALU_DISPATCH_LDI_EN
          else if (is_ldi) state_d = StLdiWb;
`endif
          else             illegal_d = 1'b1;
        end
      end
      StIssue: begin
        cnt_d   = 3'(ALU_LAT);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = StWb;
      end
      StWb: begin
        rf_we   = 1'b1;
        state_d = StIdle;
      end
`ifdef ALU_DISPATCH_LDI_EN
      StLdiWb: begin
        rf_we    = 1'b1;
        rf_wdata = DATA_W'(imm_f(instr_q));
        state_d  = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State, latched instruction, held ALU operands and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      illegal_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      if (accept) instr_q <= instr;
      if (state_q == StIssue) begin
        alu_a_q   <= rf_a;
        alu_b_q   <= rf_b;
        alu_sel_q <= op_f(instr_q);
      end
      if (state_q == StWb) flags_q <= alu_flags;
    end
  end

  // Outputs: operands read live in ISSUE, then held from the captured copy
  always_comb begin
    instr_ready = state_q == StIdle;
    alu_en      = state_q == StIssue;
    alu_a       = alu_en ? rf_a : alu_a_q;
    alu_b       = alu_en ? rf_b : alu_b_q;
    alu_sel     = alu_en ? op_f(instr_q) : alu_sel_q;
    retire      = state_q == StWb;
`ifdef ALU_DISPATCH_LDI_EN
    if (state_q == StLdiWb) retire = 1'b1;
`endif
    illegal     = illegal_q;
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: stimulus pushes expected ALU issues,
// retire latencies and illegal pulses; a negedge monitor pops and compares.
// A stub ALU returns scripted results ALU_LAT cycles after each alu_en.
module tb_alu_dispatch;

  localparam int unsigned NREGS   = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ALU_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_en, retire, illegal;
  logic [2:0]  alu_flags, flags_q;
  logic [2:0]  dbg_raddr = 3'd0;
  logic [7:0]  dbg_rdata;

  alu_dispatch #(
    .NREGS   (NREGS),
    .DATA_W  (DATA_W),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_en      (alu_en),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .flags_q     (flags_q),
    .retire      (retire),
    .illegal     (illegal),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } issue_t;

  issue_t      exp_issue_q[$];
  int          exp_ret_q[$];
  int          exp_ill_q[$];
  logic [10:0] stub_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  model_rf[8];
  logic [2:0]  model_flags = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Stub ALU: result becomes valid ALU_LAT cycles after the alu_en cycle, then holds
  logic [7:0] stub_out = 8'h00;
  logic [2:0] stub_flags = 3'b000;
  logic       stub_live = 1'b0;
  int         stub_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_live <= 1'b0;
      stub_cnt  <= 0;
    end else if (alu_en) begin
      if (stub_q.size() > 0) {stub_out, stub_flags} <= stub_q.pop_front();
      stub_live <= 1'b1;
      stub_cnt  <= int'(ALU_LAT) - 1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign alu_out   = (stub_live && stub_cnt == 0) ? stub_out : 8'hEE;
  assign alu_flags = (stub_live && stub_cnt == 0) ? stub_flags : 3'b111;

  // Monitor: compares every DUT event against the scoreboard queues
  int     cyc = 0;
  int     acc_cyc = 0;
  issue_t mon_e;
  int     mon_lat;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (alu_en) begin
        if (exp_issue_q.size() == 0) unexpected("alu_en");
        else begin
          mon_e = exp_issue_q.pop_front();
          check("issue {a,b,sel}", 32'({alu_a, alu_b, alu_sel}), 32'(mon_e));
        end
      end
      if (retire) begin
        if (exp_ret_q.size() == 0) unexpected("retire");
        else begin
          mon_lat = exp_ret_q.pop_front();
          check("retire latency", 32'(cyc - acc_cyc), 32'(mon_lat));
        end
      end
      if (illegal) begin
        if (exp_ill_q.size() == 0) unexpected("illegal");
        else begin
          mon_lat = exp_ill_q.pop_front();
          check("illegal latency", 32'(cyc - acc_cyc), 32'(mon_lat));
        end
      end
      if (instr_valid && instr_ready) acc_cyc = cyc;
    end
  end

  // Present one word and hold valid until it is accepted
  task automatic send(input logic [15:0] w);
    bit got = 1'b0;
    @(posedge clk);
    #1 instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) unexpected("accept timeout");
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 16'h0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] res, input logic [2:0] fl);
    exp_issue_q.push_back('{a: model_rf[rs1], b: model_rf[rs2], sel: op});
    stub_q.push_back({res, fl});
    exp_ret_q.push_back(2 + int'(ALU_LAT));
    send({op, rd, rs1, rs2, 3'b000});
    model_rf[rd] = res;
    model_flags  = fl;
    repeat (ALU_LAT + 3) @(negedge clk);
  endtask

  task automatic load(input logic [2:0] rd, input logic [7:0] val);
`ifdef ALU_DISPATCH_LDI_EN
    exp_ret_q.push_back(1);
    send({4'hF, rd, 1'b0, val});
    model_rf[rd] = val;
    repeat (2) @(negedge clk);
`else
    alu_op(4'h8, rd, 3'd0, 3'd0, val, 3'b000);
`endif
  endtask

  task automatic check_rf();
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i);
      #1 check($sformatf("rf r%0d", i), 32'(dbg_rdata), 32'(model_rf[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    bit seen;
    for (int i = 0; i < 8; i++) model_rf[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset alu_en", 32'(alu_en), 32'd0);
    check("reset retire", 32'(retire), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset flags_q", 32'(flags_q), 32'd0);
    check("reset alu_a/b/sel", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("instr_ready after reset", 32'(instr_ready), 32'd1);
    check_rf();

    // Operand loads and ADD r3,r1,r2
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    alu_op(4'h0, 3'd3, 3'd1, 3'd2, 8'h08, 3'b000);
    check_rf();
    check("flags after add", 32'(flags_q), 32'(model_flags));

    // SUB r4,r2,r2 producing zero flag
    alu_op(4'h1, 3'd4, 3'd2, 3'd2, 8'h00, 3'b001);
    check("flags after sub", 32'(flags_q), 32'h1);
    check_rf();

    // Undefined opcode 0xC is dropped with an illegal pulse
    exp_ill_q.push_back(1);
    send(16'hC650);
    @(negedge clk);
    check("ready after illegal", 32'(instr_ready), 32'd1);
    repeat (2) @(negedge clk);
    check_rf();
    check("flags after illegal", 32'(flags_q), 32'(model_flags));

`ifndef ALU_DISPATCH_LDI_EN
    // Without LDI, op 0xF is illegal too
    exp_ill_q.push_back(1);
    send(16'hF2AA);
    @(negedge clk);
    check("ready after op F", 32'(instr_ready), 32'd1);
    repeat (2) @(negedge clk);
    check_rf();
`endif

    // Back-to-back: XOR r6,r1,r2 then NOT r7,r1,r3 with valid held high
    exp_issue_q.push_back('{a: 8'h05, b: 8'h03, sel: 4'h4});
    exp_issue_q.push_back('{a: 8'h05, b: 8'h08, sel: 4'h5});
    stub_q.push_back({8'h06, 3'b000});
    stub_q.push_back({8'hFA, 3'b100});
    exp_ret_q.push_back(2 + int'(ALU_LAT));
    exp_ret_q.push_back(2 + int'(ALU_LAT));
    @(posedge clk);
    #1 instr = 16'h4C50;
    instr_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) unexpected("first accept timeout");
    @(posedge clk);
    #1 instr = 16'h5E58;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) break;
      busy++;
    end
    check("busy cycles between accepts", 32'(busy), 32'(2 + ALU_LAT));
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 16'h0;
    repeat (ALU_LAT + 3) @(negedge clk);
    model_rf[6] = 8'h06;
    model_rf[7] = 8'hFA;
    model_flags = 3'b100;
    check_rf();
    check("flags after not", 32'(flags_q), 32'h4);

    // Reset during WAIT of ADD r5,r1,r2 aborts the writeback
    exp_issue_q.push_back('{a: 8'h05, b: 8'h03, sel: 4'h0});
    stub_q.push_back({8'h08, 3'b000});
    send(16'h0A50);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (alu_en) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) unexpected("abort issue timeout");
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) model_rf[i] = 8'h00;
    model_flags = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("ready after abort", 32'(instr_ready), 32'd1);
    check("flags after abort", 32'(flags_q), 32'd0);
    check_rf();

    check("issue queue drained", 32'(exp_issue_q.size()), 32'd0);
    check("retire queue drained", 32'(exp_ret_q.size()), 32'd0);
    check("illegal queue drained", 32'(exp_ill_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
